// File: rtl/ysyx_2022040010_csr_pkg.sv
// Shared definitions for the M-mode CSR file: bus layout, CSR addresses,
// cause codes, mstatus field positions and small decode helpers.
package ysyx_2022040010_csr_pkg;

  localparam int WB_TO_CSR_WD  = 77;
  localparam int BUS_WE_BIT    = 76;
  localparam int BUS_ADDR_HI   = 75;
  localparam int BUS_ADDR_LO   = 64;
  localparam int BUS_DATA_HI   = 63;
  localparam int BUS_DATA_LO   = 0;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [63:0] MISA_VAL = 64'h8000_0000_0000_1100;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
  } wb_csr_t;

  // Architectural view of mstatus: MPP is hardwired to M-mode.
  function automatic logic [63:0] mstatus_view(input logic mpie, input logic mie);
    logic [63:0] v;
    v = '0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    v[MSTATUS_MPIE] = mpie;
    v[MSTATUS_MIE]  = mie;
    return v;
  endfunction

  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MINSTRET: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_2022040010_csr.sv
// Machine-mode CSR file with write bypass, mcycle/minstret counters and a
// two-state trap sequencer that emits a one-cycle redirect for ecall/mret.
module ysyx_2022040010_csr #(
  parameter int          WB_TO_CSR_WD = 77,
  parameter logic [63:0] MTVEC_RST    = 64'h0,
  parameter logic [63:0] MHARTID      = 64'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [WB_TO_CSR_WD-1:0] wb_to_csr_bus,
  input  logic                    wb_retire,
  input  logic [63:0]             wb_pc,
  input  logic                    wb_ecall,
  input  logic                    wb_mret,
  input  logic [11:0]             csr_raddr,
  output logic [63:0]             csr_rdata,
  output logic                    trap_redirect,
  output logic [63:0]             trap_target
);
  import ysyx_2022040010_csr_pkg::*;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  wb_csr_t     bus;
  logic        retire;
  logic        do_ecall;
  logic        do_mret;
  logic        trap;
  logic        wr_en;
  logic [63:0] wr_val;
  logic [63:0] stored_rdata;

  logic [0:0]  state;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [63:0] mie_csr;
  logic [63:0] mtvec;
  logic [63:0] mscratch;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic unused_inputs;
  assign unused_inputs = ^{stall[5:4], stall[2:0], wb_pc[1:0]};

  // Masks a write value into exactly what a later read of that CSR returns.
  function automatic logic [63:0] mask_wdata(input logic [11:0] addr, input logic [63:0] data);
    case (addr)
      CSR_MSTATUS:         return mstatus_view(data[MSTATUS_MPIE], data[MSTATUS_MIE]);
      CSR_MTVEC, CSR_MEPC: return {data[63:2], 2'b00};
      default:             return data;
    endcase
  endfunction

  assign bus      = wb_csr_t'(wb_to_csr_bus);
  assign retire   = wb_retire & ~stall[3];
  assign do_ecall = retire & wb_ecall;
  assign do_mret  = retire & wb_mret & ~wb_ecall;
  assign trap     = do_ecall | do_mret;
  // A trapping instruction never commits its own CSR write.
  assign wr_en    = retire & bus.we & ~trap & csr_writable(bus.addr);
  assign wr_val   = mask_wdata(bus.addr, bus.data);

  always_comb begin
    stored_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:  stored_rdata = mstatus_view(mstatus_mpie, mstatus_mie);
      CSR_MISA:     stored_rdata = MISA_VAL;
      CSR_MIE:      stored_rdata = mie_csr;
      CSR_MTVEC:    stored_rdata = mtvec;
      CSR_MSCRATCH: stored_rdata = mscratch;
      CSR_MEPC:     stored_rdata = mepc;
      CSR_MCAUSE:   stored_rdata = mcause;
      CSR_MIP:      stored_rdata = '0;
      CSR_MCYCLE:   stored_rdata = mcycle;
      CSR_MINSTRET: stored_rdata = minstret;
      CSR_MHARTID:  stored_rdata = MHARTID;
      default:      stored_rdata = '0;
    endcase
  end

  assign csr_rdata     = (wr_en && bus.addr == csr_raddr) ? wr_val : stored_rdata;
  assign trap_redirect = (state == REDIRECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      trap_target  <= '0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_csr      <= '0;
      mtvec        <= {MTVEC_RST[63:2], 2'b00};
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
    end else begin
      state <= trap ? REDIRECT : IDLE;
      if (do_ecall) begin
        mepc         <= {wb_pc[63:2], 2'b00};
        mcause       <= CAUSE_ECALL_M;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        trap_target  <= {mtvec[63:2], 2'b00};
      end else if (do_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        trap_target  <= mepc;
      end
      if (wr_en) begin
        case (bus.addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= wr_val[MSTATUS_MIE];
            mstatus_mpie <= wr_val[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_csr  <= wr_val;
          CSR_MTVEC:    mtvec    <= wr_val;
          CSR_MSCRATCH: mscratch <= wr_val;
          CSR_MEPC:     mepc     <= wr_val;
          CSR_MCAUSE:   mcause   <= wr_val;
          default: ;
        endcase
      end
    end
  end

  // An explicit write to a counter replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= (wr_en && bus.addr == CSR_MCYCLE)   ? wr_val : mcycle + 64'd1;
      minstret <= (wr_en && bus.addr == CSR_MINSTRET) ? wr_val : minstret + 64'(retire);
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_csr.sv
// Scoreboard bench for the CSR file: stimulus queues expected read data and
// redirects; a negedge monitor pops and compares them against the DUT.
module tb_ysyx_2022040010_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [76:0] wb_to_csr_bus;
  logic        wb_retire;
  logic [63:0] wb_pc;
  logic        wb_ecall;
  logic        wb_mret;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic        trap_redirect;
  logic [63:0] trap_target;

  ysyx_2022040010_csr #(
    .WB_TO_CSR_WD(77),
    .MTVEC_RST(64'h0),
    .MHARTID(64'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .wb_to_csr_bus(wb_to_csr_bus),
    .wb_retire(wb_retire),
    .wb_pc(wb_pc),
    .wb_ecall(wb_ecall),
    .wb_mret(wb_mret),
    .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata),
    .trap_redirect(trap_redirect),
    .trap_target(trap_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    string       name;
    logic [63:0] exp;
  } chk_t;

  typedef struct {
    int          at_cyc;
    logic [63:0] tgt;
    string       name;
  } trap_t;

  chk_t  chk_q[$];
  trap_t trap_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    base   = 0;
  int    n_ret  = 0;

  // Monitor: kind 0 compares csr_rdata, kind 1 compares trap_redirect.
  always @(negedge clk) begin
    chk_t        c;
    trap_t       t;
    logic [63:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      act = (c.kind == 0) ? csr_rdata : {63'b0, trap_redirect};
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
    if (trap_redirect === 1'b1) begin
      n_chk++;
      if (trap_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect: got target %h expected no redirect (cycle %0d)", trap_target, cyc);
      end else begin
        t = trap_q.pop_front();
        if (t.at_cyc != cyc || trap_target !== t.tgt) begin
          n_fail++;
          $display("FAIL %s: got cycle %0d target %h expected cycle %0d target %h",
                   t.name, cyc, trap_target, t.at_cyc, t.tgt);
        end
      end
    end else if (trap_q.size() > 0 && trap_q[0].at_cyc <= cyc) begin
      t = trap_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no redirect expected redirect at cycle %0d target %h", t.name, t.at_cyc, t.tgt);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_to_csr_bus = '0;
    wb_retire     = 1'b0;
    wb_ecall      = 1'b0;
    wb_mret       = 1'b0;
    wb_pc         = '0;
    stall         = '0;
  endtask

  task automatic expect_now(input int kind, input logic [63:0] exp, input string name);
    chk_q.push_back('{kind, name, exp});
  endtask

  task automatic chk(input logic [11:0] addr, input logic [63:0] exp, input string name);
    csr_raddr = addr;
    expect_now(0, exp, name);
    step();
  endtask

  task automatic retire(input logic we, input logic [11:0] addr, input logic [63:0] data, input logic st3);
    wb_to_csr_bus = {we, addr, data};
    wb_retire     = 1'b1;
    stall[3]      = st3;
    if (!st3) n_ret++;
    step();
    idle();
  endtask

  task automatic trap_ret(input logic ec, input logic mr, input logic [63:0] pc,
                          input logic we, input logic [11:0] addr, input logic [63:0] data,
                          input logic [63:0] exp_tgt, input string name);
    wb_to_csr_bus = {we, addr, data};
    wb_retire     = 1'b1;
    wb_ecall      = ec;
    wb_mret       = mr;
    wb_pc         = pc;
    n_ret++;
    trap_q.push_back('{cyc + 1, exp_tgt, name});
    step();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    idle();
    csr_raddr = '0;
    rst = 1'b1;
    step();
    do_reset();

    // Reset state of every implemented CSR
    expect_now(1, 64'd0, "redirect_rst");
    chk(12'h300, 64'h1800, "mstatus_rst");
    chk(12'h301, 64'h8000_0000_0000_1100, "misa_rst");
    chk(12'h304, 64'h0, "mie_rst");
    chk(12'h305, 64'h0, "mtvec_rst");
    chk(12'h340, 64'h0, "mscratch_rst");
    chk(12'h341, 64'h0, "mepc_rst");
    chk(12'h342, 64'h0, "mcause_rst");
    chk(12'h344, 64'h0, "mip_rst");
    chk(12'hB00, 64'(cyc - base), "mcycle_rst");
    chk(12'hB02, 64'h0, "minstret_rst");
    chk(12'hF14, 64'h0, "mhartid_rst");
    chk(12'h7C0, 64'h0, "unimpl_rst");

    // Same-cycle bypass on mtvec write, then persistence
    csr_raddr = 12'h305;
    expect_now(0, 64'hDEAD_BEEF_0000_0004, "mtvec_bypass");
    retire(1'b1, 12'h305, 64'hDEAD_BEEF_0000_0007, 1'b0);
    chk(12'h305, 64'hDEAD_BEEF_0000_0004, "mtvec_persist");
    csr_raddr = 12'h305;
    expect_now(0, 64'hDEAD_BEEF_0000_0004, "mtvec_stalled_nobypass");
    retire(1'b1, 12'h305, 64'h1234_5678_9ABC_DEF0, 1'b1);
    chk(12'h305, 64'hDEAD_BEEF_0000_0004, "mtvec_stalled");
    retire(1'b1, 12'h301, 64'h0, 1'b0);
    chk(12'h301, 64'h8000_0000_0000_1100, "misa_readonly");
    chk(12'hB02, 64'd2, "minstret_stall_skip");

    // ecall trap
    retire(1'b1, 12'h305, 64'h8000_0100, 1'b0);
    retire(1'b1, 12'h300, 64'h8, 1'b0);
    chk(12'h300, 64'h1808, "mstatus_mie_set");
    trap_ret(1'b1, 1'b0, 64'h8000_0040, 1'b0, 12'h0, 64'h0, 64'h8000_0100, "ecall_redirect");
    chk(12'h341, 64'h8000_0040, "mepc_ecall");
    expect_now(1, 64'd0, "redirect_one_cycle");
    chk(12'h342, 64'd11, "mcause_ecall");
    chk(12'h300, 64'h1880, "mstatus_ecall");

    // mret, then ecall with a dropped write, then ecall+mret while in REDIRECT
    trap_ret(1'b0, 1'b1, 64'h8000_0100, 1'b0, 12'h0, 64'h0, 64'h8000_0040, "mret_redirect");
    chk(12'h300, 64'h1888, "mstatus_mret");
    retire(1'b1, 12'h340, 64'h55, 1'b0);
    trap_ret(1'b1, 1'b0, 64'h8000_0080, 1'b1, 12'h340, 64'hAA, 64'h8000_0100, "ecall_we_redirect");
    trap_ret(1'b1, 1'b1, 64'h8000_00C0, 1'b0, 12'h0, 64'h0, 64'h8000_0100, "ecall_mret_redirect");
    chk(12'h340, 64'h55, "mscratch_write_dropped");
    chk(12'h341, 64'h8000_00C0, "mepc_back_to_back");
    chk(12'h300, 64'h1800, "mstatus_ecall_wins");
    chk(12'hB02, 64'(n_ret), "minstret_count");

    // minstret wrap with bubbles, mcycle tracks elapsed cycles
    chk(12'hB00, 64'(cyc - base), "mcycle_before");
    retire(1'b1, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    retire(1'b0, 12'h0, 64'h0, 1'b0);
    step();
    step();
    retire(1'b0, 12'h0, 64'h0, 1'b0);
    step();
    step();
    retire(1'b0, 12'h0, 64'h0, 1'b0);
    chk(12'hB02, 64'd2, "minstret_wrap");
    chk(12'hB00, 64'(cyc - base), "mcycle_after");

    // Reset while redirect is high
    trap_ret(1'b1, 1'b0, 64'h8000_0200, 1'b0, 12'h0, 64'h0, 64'h8000_0100, "ecall_before_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = cyc;
    expect_now(1, 64'd0, "redirect_after_rst");
    chk(12'h341, 64'h0, "mepc_after_rst");
    chk(12'hB00, 64'(cyc - base), "mcycle_restart");
    chk(12'h305, 64'h0, "mtvec_after_rst");

    step();
    step();
    n_chk++;
    if (trap_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_redirects: got %0d outstanding expected 0", trap_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
